rt_context_swapper: RTL and testbench

Context save/restore engine that drives the register-file debug port (PD port) of a single RT core. On a swap request from the thread scheduler it halts the core in kernel mode. It then reads the running thread's 32 scalar and 16 vector registers into an on-chip context store and writes the next thread's registers back through the same port. It sits between the scheduler and the RT core.

---
 rtl/rt_context_swapper.sv | 173 +++++++++++++++++
 tb/tb_rt_context_swapper.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_context_swapper.sv
// rt_context_swapper: context save/restore engine for one RT core.
//
// On swap_req (sampled only in IDLE) the core is held in kernel mode and the engine
// optionally saves the running thread's 32 scalar and 16 vector registers into an
// on-chip store slot (SAVE, 16 cycles). It then writes the next thread's registers
// from another slot back into the core (LOAD, 32 cycles). A one-cycle swap_done
// pulse follows (DONE).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   swap_req/save_en           start a swap; save_en selects save-then-load vs load only
//   save_ctx/load_ctx          store slots for the outgoing / incoming thread
//   swap_busy/swap_done        status; swap_done is a one-cycle pulse in DONE
//   ctx_wr_*                   host preload of one store entry per cycle (IDLE only)
//   Kernel_mode                to core, high while a swap is in progress
//   PD_*                       register-file debug port (combinational reads, write enables)
module rt_context_swapper #(
  parameter int unsigned NUM_CTX = 4,
  parameter int unsigned CTX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               swap_req,
  input  logic               save_en,
  input  logic [CTX_W-1:0]   save_ctx,
  input  logic [CTX_W-1:0]   load_ctx,
  output logic               swap_busy,
  output logic               swap_done,
  input  logic               ctx_wr_en,
  input  logic [CTX_W-1:0]   ctx_wr_ctx,
  input  logic               ctx_wr_vec,
  input  logic [4:0]         ctx_wr_addr,
  input  logic [127:0]       ctx_wr_data,
  output logic               Kernel_mode,
  output logic               PD_scalar_wen,
  output logic               PD_vector_wen,
  output logic [4:0]         PD_scalar_wb_address,
  output logic [3:0]         PD_vector_wb_address,
  output logic [31:0]        PD_scalar_wb_data,
  output logic [127:0]       PD_vector_wb_data,
  output logic [4:0]         PD_scalar_read_address1,
  output logic [4:0]         PD_scalar_read_address2,
  output logic [3:0]         PD_vector_read_address1,
  output logic [3:0]         PD_vector_read_address2,
  input  logic [31:0]        PD_scalar_read1,
  input  logic [31:0]        PD_scalar_read2,
  input  logic [127:0]       PD_vector_read1,
  input  logic [127:0]       PD_vector_read2
);

  typedef enum logic [1:0] {StIdle, StSave, StLoad, StDone} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [CTX_W-1:0] save_ctx_q, save_ctx_d;
  logic [CTX_W-1:0] load_ctx_q, load_ctx_d;

  // Context store; deliberately not reset.
  logic [31:0]  store_s [NUM_CTX][32];
  logic [127:0] store_v [NUM_CTX][16];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      save_ctx_q <= '0;
      load_ctx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      save_ctx_q <= save_ctx_d;
      load_ctx_q <= load_ctx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    save_ctx_d = save_ctx_q;
    load_ctx_d = load_ctx_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (swap_req) begin
          save_ctx_d = save_ctx;
          load_ctx_d = load_ctx;
          state_d    = save_en ? StSave : StLoad;
        end
      end
      StSave: begin
        if (cnt_q == 5'd15) begin
          state_d = StLoad;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StLoad: begin
        if (cnt_q == 5'd31) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from registered state and counter
  always_comb begin
    swap_busy               = (state_q != StIdle);
    Kernel_mode             = (state_q != StIdle);
    swap_done               = (state_q == StDone);
    PD_scalar_wen           = 1'b0;
    PD_vector_wen           = 1'b0;
    PD_scalar_wb_address    = '0;
    PD_vector_wb_address    = '0;
    PD_scalar_wb_data       = '0;
    PD_vector_wb_data       = '0;
    PD_scalar_read_address1 = '0;
    PD_scalar_read_address2 = '0;
    PD_vector_read_address1 = '0;
    PD_vector_read_address2 = '0;
    case (state_q)
      StSave: begin
        // Two scalar registers per cycle; vectors only occupy the first 8 counts.
        PD_scalar_read_address1 = {cnt_q[3:0], 1'b0};
        PD_scalar_read_address2 = {cnt_q[3:0], 1'b1};
        if (!cnt_q[3]) begin
          PD_vector_read_address1 = {cnt_q[2:0], 1'b0};
          PD_vector_read_address2 = {cnt_q[2:0], 1'b1};
        end
      end
      StLoad: begin
        PD_scalar_wen        = 1'b1;
        PD_scalar_wb_address = cnt_q;
        PD_scalar_wb_data    = store_s[load_ctx_q][cnt_q];
        if (!cnt_q[4]) begin
          PD_vector_wen        = 1'b1;
          PD_vector_wb_address = cnt_q[3:0];
          PD_vector_wb_data    = store_v[load_ctx_q][cnt_q[3:0]];
        end
      end
      default: ;
    endcase
  end

  // Store writes: host preload in IDLE, captured read data in SAVE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StIdle && ctx_wr_en) begin
        if (ctx_wr_vec) begin
          store_v[ctx_wr_ctx][ctx_wr_addr[3:0]] <= ctx_wr_data;
        end else begin
          store_s[ctx_wr_ctx][ctx_wr_addr] <= ctx_wr_data[31:0];
        end
      end
      if (state_q == StSave) begin
        store_s[save_ctx_q][{cnt_q[3:0], 1'b0}] <= PD_scalar_read1;
        store_s[save_ctx_q][{cnt_q[3:0], 1'b1}] <= PD_scalar_read2;
        if (!cnt_q[3]) begin
          store_v[save_ctx_q][{cnt_q[2:0], 1'b0}] <= PD_vector_read1;
          store_v[save_ctx_q][{cnt_q[2:0], 1'b1}] <= PD_vector_read2;
        end
      end
    end
  end

endmodule

// File: tb/tb_rt_context_swapper.sv
module tb_rt_context_swapper;
  localparam int unsigned NUM_CTX = 4;
  localparam int unsigned CTX_W   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               swap_req = 1'b0, save_en = 1'b0;
  logic [CTX_W-1:0]   save_ctx = '0, load_ctx = '0;
  logic               swap_busy, swap_done, Kernel_mode;
  logic               ctx_wr_en = 1'b0, ctx_wr_vec = 1'b0;
  logic [CTX_W-1:0]   ctx_wr_ctx = '0;
  logic [4:0]         ctx_wr_addr = '0;
  logic [127:0]       ctx_wr_data = '0;
  logic               PD_scalar_wen, PD_vector_wen;
  logic [4:0]         PD_scalar_wb_address, PD_scalar_read_address1, PD_scalar_read_address2;
  logic [3:0]         PD_vector_wb_address, PD_vector_read_address1, PD_vector_read_address2;
  logic [31:0]        PD_scalar_wb_data, PD_scalar_read1, PD_scalar_read2;
  logic [127:0]       PD_vector_wb_data, PD_vector_read1, PD_vector_read2;

  int n_checks = 0;
  int n_fail   = 0;

  rt_context_swapper #(.NUM_CTX(NUM_CTX), .CTX_W(CTX_W)) dut (
    .clk(clk), .rst(rst), .swap_req(swap_req), .save_en(save_en),
    .save_ctx(save_ctx), .load_ctx(load_ctx), .swap_busy(swap_busy), .swap_done(swap_done),
    .ctx_wr_en(ctx_wr_en), .ctx_wr_ctx(ctx_wr_ctx), .ctx_wr_vec(ctx_wr_vec),
    .ctx_wr_addr(ctx_wr_addr), .ctx_wr_data(ctx_wr_data), .Kernel_mode(Kernel_mode),
    .PD_scalar_wen(PD_scalar_wen), .PD_vector_wen(PD_vector_wen),
    .PD_scalar_wb_address(PD_scalar_wb_address), .PD_vector_wb_address(PD_vector_wb_address),
    .PD_scalar_wb_data(PD_scalar_wb_data), .PD_vector_wb_data(PD_vector_wb_data),
    .PD_scalar_read_address1(PD_scalar_read_address1),
    .PD_scalar_read_address2(PD_scalar_read_address2),
    .PD_vector_read_address1(PD_vector_read_address1),
    .PD_vector_read_address2(PD_vector_read_address2),
    .PD_scalar_read1(PD_scalar_read1), .PD_scalar_read2(PD_scalar_read2),
    .PD_vector_read1(PD_vector_read1), .PD_vector_read2(PD_vector_read2)
  );

  // Core register-file model: combinational reads, writes on the clock edge.
  logic [31:0]  core_s [32];
  logic [127:0] core_v [16];
  logic         poke_en = 1'b0, poke_vec = 1'b0;
  logic [4:0]   poke_idx = '0;
  logic [127:0] poke_val = '0;

  assign PD_scalar_read1 = core_s[PD_scalar_read_address1];
  assign PD_scalar_read2 = core_s[PD_scalar_read_address2];
  assign PD_vector_read1 = core_v[PD_vector_read_address1];
  assign PD_vector_read2 = core_v[PD_vector_read_address2];

  always @(posedge clk) begin
    if (PD_scalar_wen) core_s[PD_scalar_wb_address] <= PD_scalar_wb_data;
    if (PD_vector_wen) core_v[PD_vector_wb_address] <= PD_vector_wb_data;
    if (poke_en) begin
      if (poke_vec) core_v[poke_idx[3:0]] <= poke_val;
      else          core_s[poke_idx]      <= poke_val[31:0];
    end
  end

  // Every-cycle invariants
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (Kernel_mode !== swap_busy) begin
        n_fail++;
        $display("FAIL kmode_eq_busy t=%0t: got %b expected %b", $time, Kernel_mode, swap_busy);
      end
      n_checks++;
      if ((PD_scalar_wen || PD_vector_wen) && (!swap_busy || swap_done)) begin
        n_fail++;
        $display("FAIL wen_outside_load t=%0t: got wen=%b%b expected 00", $time,
                 PD_scalar_wen, PD_vector_wen);
      end
    end
  end

  function automatic logic [127:0] vrep(input int w);
    logic [31:0] x;
    x = 32'(w);
    return {x, x, x, x};
  endfunction

  task automatic preload(input int ctx, input bit vec, input int addr, input logic [127:0] d);
    @(negedge clk);
    ctx_wr_en = 1'b1; ctx_wr_ctx = ctx[CTX_W-1:0]; ctx_wr_vec = vec;
    ctx_wr_addr = addr[4:0]; ctx_wr_data = d;
    @(posedge clk); #1;
    ctx_wr_en = 1'b0;
  endtask

  task automatic poke(input bit vec, input int idx, input logic [127:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_vec = vec; poke_idx = idx[4:0]; poke_val = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Returns just after edge 0; the next negedge samples cycle 1.
  task automatic start_swap(input bit sv, input int sc, input int lc);
    @(negedge clk);
    swap_req = 1'b1; save_en = sv; save_ctx = sc[CTX_W-1:0]; load_ctx = lc[CTX_W-1:0];
    @(posedge clk); #1;
    swap_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({swap_busy, swap_done, Kernel_mode} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got %b expected 000", {swap_busy, swap_done, Kernel_mode});
    end
    n_checks++;
    if ({PD_scalar_wen, PD_vector_wen} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_wen: got %b expected 00", {PD_scalar_wen, PD_vector_wen});
    end
    n_checks++;
    if ({PD_scalar_wb_address, PD_vector_wb_address, PD_scalar_read_address1,
         PD_scalar_read_address2, PD_vector_read_address1, PD_vector_read_address2} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got nonzero address expected 0");
    end
    n_checks++;
    if ({PD_scalar_wb_data, PD_vector_wb_data} !== 160'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {PD_scalar_wb_data, PD_vector_wb_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_load_only();
    int sw, vw;
    for (int i = 0; i < 32; i++) preload(1, 1'b0, i, 128'(32'h1000 + i));
    for (int i = 0; i < 16; i++) preload(1, 1'b1, i, vrep(32'hA0 + i));
    for (int i = 0; i < 32; i++) poke(1'b0, i, 128'hFFFF_FFFF);
    sw = 0; vw = 0;
    start_swap(1'b0, 0, 1);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      sw += int'(PD_scalar_wen);
      vw += int'(PD_vector_wen);
      if (c <= 32) begin
        n_checks++;
        if ({swap_busy, PD_scalar_wen, PD_scalar_wb_address, PD_scalar_wb_data} !==
            {1'b1, 1'b1, 5'(c - 1), 32'h1000 + 32'(c - 1)}) begin
          n_fail++;
          $display("FAIL load_scalar c=%0d: got %b/%0d/%h expected 1/%0d/%h", c, PD_scalar_wen,
                   PD_scalar_wb_address, PD_scalar_wb_data, c - 1, 32'h1000 + 32'(c - 1));
        end
        n_checks++;
        if (PD_vector_wen !== (c <= 16)) begin
          n_fail++;
          $display("FAIL load_vwen c=%0d: got %b expected %b", c, PD_vector_wen, c <= 16);
        end else if (c <= 16) begin
          n_checks++;
          if ({PD_vector_wb_address, PD_vector_wb_data} !== {4'(c - 1), vrep(32'hA0 + c - 1)}) begin
            n_fail++;
            $display("FAIL load_vector c=%0d: got %0d/%h expected %0d/%h", c,
                     PD_vector_wb_address, PD_vector_wb_data, c - 1, vrep(32'hA0 + c - 1));
          end
        end
      end
      if (c == 33 || c == 34) begin
        n_checks++;
        if ({swap_done, swap_busy} !== ((c == 33) ? 2'b11 : 2'b00)) begin
          n_fail++;
          $display("FAIL load_done c=%0d: got done/busy=%b%b", c, swap_done, swap_busy);
        end
      end
    end
    n_checks++;
    if (sw != 32 || vw != 16) begin
      n_fail++;
      $display("FAIL load_counts: got %0d/%0d expected 32/16", sw, vw);
    end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (core_s[i] !== 32'h1000 + 32'(i)) begin
        n_fail++;
        $display("FAIL load_core_s[%0d]: got %h expected %h", i, core_s[i], 32'h1000 + i);
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (core_v[i] !== vrep(32'hA0 + i)) begin
        n_fail++;
        $display("FAIL load_core_v[%0d]: got %h expected %h", i, core_v[i], vrep(32'hA0 + i));
      end
    end
  endtask

  task automatic test_save_swap();
    for (int i = 0; i < 32; i++) poke(1'b0, i, 128'(i));
    for (int i = 0; i < 16; i++) poke(1'b1, i, 128'(i * 3));
    start_swap(1'b1, 0, 1);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        n_checks++;
        if ({swap_busy, PD_scalar_wen, PD_vector_wen, PD_scalar_read_address1,
             PD_scalar_read_address2} !== {3'b100, 5'(2 * (c - 1)), 5'(2 * (c - 1) + 1)}) begin
          n_fail++;
          $display("FAIL save_scalar_rd c=%0d: got %0d/%0d wen=%b%b expected %0d/%0d", c,
                   PD_scalar_read_address1, PD_scalar_read_address2, PD_scalar_wen,
                   PD_vector_wen, 2 * (c - 1), 2 * (c - 1) + 1);
        end
        if (c <= 8) begin
          n_checks++;
          if ({PD_vector_read_address1, PD_vector_read_address2} !==
              {4'(2 * (c - 1)), 4'(2 * (c - 1) + 1)}) begin
            n_fail++;
            $display("FAIL save_vector_rd c=%0d: got %0d/%0d expected %0d/%0d", c,
                     PD_vector_read_address1, PD_vector_read_address2, 2 * (c - 1), 2 * c - 1);
          end
        end
      end else if (c <= 48) begin
        n_checks++;
        if ({PD_scalar_wen, PD_scalar_wb_address, PD_scalar_wb_data} !==
            {1'b1, 5'(c - 17), 32'h1000 + 32'(c - 17)}) begin
          n_fail++;
          $display("FAIL save_load_wr c=%0d: got %b/%0d/%h expected 1/%0d/%h", c, PD_scalar_wen,
                   PD_scalar_wb_address, PD_scalar_wb_data, c - 17, 32'h1000 + 32'(c - 17));
        end
      end else begin
        n_checks++;
        if ({swap_done, swap_busy} !== ((c == 49) ? 2'b11 : 2'b00)) begin
          n_fail++;
          $display("FAIL save_done c=%0d: got done/busy=%b%b", c, swap_done, swap_busy);
        end
      end
    end
    // Slot 0 must now hold the model; observe it by loading it back into the core.
    start_swap(1'b0, 0, 0);
    repeat (34) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (core_s[i] !== 32'(i)) begin
        n_fail++;
        $display("FAIL slot0_s[%0d]: got %h expected %h", i, core_s[i], 32'(i));
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (core_v[i] !== 128'(i * 3)) begin
        n_fail++;
        $display("FAIL slot0_v[%0d]: got %h expected %h", i, core_v[i], 128'(i * 3));
      end
    end
  endtask

  task automatic test_same_slot();
    poke(1'b0, 5, 128'hDEAD);
    start_swap(1'b1, 2, 2);
    repeat (50) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (core_s[i] !== ((i == 5) ? 32'hDEAD : 32'(i))) begin
        n_fail++;
        $display("FAIL same_slot_s[%0d]: got %h expected %h", i, core_s[i],
                 (i == 5) ? 32'hDEAD : 32'(i));
      end
    end
    n_checks++;
    if (core_v[7] !== 128'd21) begin
      n_fail++;
      $display("FAIL same_slot_v7: got %h expected %h", core_v[7], 128'd21);
    end
    poke(1'b0, 5, 128'h0);
    start_swap(1'b0, 0, 2);
    repeat (34) @(negedge clk);
    n_checks++;
    if (core_s[5] !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL slot2_s5: got %h expected 0000dead", core_s[5]);
    end
  endtask

  task automatic test_busy_ignore();
    int sw;
    for (int i = 0; i < 32; i++) preload(3, 1'b0, i, 128'(32'h3000 + i));
    for (int i = 0; i < 16; i++) preload(3, 1'b1, i, vrep(32'h3300 + i));
    sw = 0;
    @(negedge clk);
    swap_req = 1'b1; save_en = 1'b0; load_ctx = 2'd3;
    @(posedge clk); #1;
    ctx_wr_en = 1'b1; ctx_wr_ctx = 2'd3; ctx_wr_data = {4{32'hBAD0_BAD0}};
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      sw += int'(PD_scalar_wen);
      ctx_wr_addr = 5'(c + 1);
      ctx_wr_vec = c[0];
      if (c == 33) begin
        n_checks++;
        if (swap_done !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_done c=33: got %b expected 1", swap_done);
        end
        swap_req = 1'b0;
        ctx_wr_en = 1'b0;
      end
      if (c >= 34) begin
        n_checks++;
        if (swap_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_single c=%0d: got busy %b expected 0", c, swap_busy);
        end
      end
    end
    n_checks++;
    if (sw != 32) begin
      n_fail++;
      $display("FAIL hold_writes: got %0d expected 32", sw);
    end
    // Overwrite the core from slot 1, then reload slot 3 to confirm the store is intact.
    start_swap(1'b0, 0, 1);
    repeat (34) @(negedge clk);
    start_swap(1'b0, 0, 3);
    repeat (34) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (core_s[i] !== 32'h3000 + 32'(i)) begin
        n_fail++;
        $display("FAIL hold_slot3_s[%0d]: got %h expected %h", i, core_s[i], 32'h3000 + i);
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (core_v[i] !== vrep(32'h3300 + i)) begin
        n_fail++;
        $display("FAIL hold_slot3_v[%0d]: got %h expected %h", i, core_v[i], vrep(32'h3300 + i));
      end
    end
  endtask

  task automatic test_reset_mid_swap();
    start_swap(1'b1, 0, 0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({swap_busy, Kernel_mode, PD_scalar_wen, PD_vector_wen, swap_done} !== 5'b00000) begin
      n_fail++;
      $display("FAIL midreset: got busy/km/swen/vwen/done=%b expected 00000",
               {swap_busy, Kernel_mode, PD_scalar_wen, PD_vector_wen, swap_done});
    end
    rst = 1'b0;
    start_swap(1'b1, 0, 0);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      n_checks++;
      if ({swap_busy, swap_done} !== ((c < 49) ? 2'b10 : (c == 49) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL after_reset c=%0d: got busy/done=%b%b", c, swap_busy, swap_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_only();
    test_save_swap();
    test_same_slot();
    test_busy_ignore();
    test_reset_mid_swap();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
